// File: rtl/ofm_tile_collector.sv
// Collects tiled OFM beats (single or dual-row) and emits linear
// channel-major write addresses for a frame of C channels.
module ofm_tile_collector #(
    parameter int DATA_W = 25,
    parameter int TI     = 16,
    parameter int TW     = 4,
    parameter int TH     = 5,
    parameter int NB     = 13,
    parameter int C      = 8,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              p0_v,
    input  logic [DATA_W-1:0] p0_data,
    input  logic              p1_v,
    input  logic [DATA_W-1:0] p1_data,
    output logic              wr0_en,
    output logic [ADDR_W-1:0] wr0_addr,
    output logic [DATA_W-1:0] wr0_data,
    output logic              wr1_en,
    output logic [ADDR_W-1:0] wr1_addr,
    output logic [DATA_W-1:0] wr1_data,
    output logic              busy,
    output logic              ch_done,
    output logic              frame_done,
    output logic              err
);
    localparam int W  = TI * TW;
    localparam int H  = TH * NB;
    localparam int CW = (TI > 1) ? $clog2(TI) : 1;
    localparam int RW = (TH > 1) ? $clog2(TH) : 1;
    localparam int TWW = (TW > 1) ? $clog2(TW) : 1;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int HW = (C > 1) ? $clog2(C) : 1;

    typedef enum logic {IDLE, RUN} state_t;
    state_t state;

    logic [CW-1:0]  col;
    logic [RW-1:0]  rib;
    logic [TWW-1:0] tile;
    logic [BW-1:0]  band;
    logic [HW-1:0]  chan;

    logic [31:0] lin;
    logic [31:0] lin1;
    logic [31:0] rib_sum;
    logic        dual;
    logic        col_wrap;
    logic        rib_wrap;
    logic        tile_wrap;
    logic        band_wrap;
    logic        chan_wrap;

    always_comb begin
        lin = 32'(chan) * 32'(H * W)
            + (32'(band) * 32'(TH) + 32'(rib)) * 32'(W)
            + 32'(tile) * 32'(TI) + 32'(col);
        lin1 = lin + 32'(W);
        // A dual beat in the last row of a band has nowhere to put row h+1
        dual = p1_v && (32'(rib) != 32'(TH - 1));
        rib_sum = 32'(rib) + (dual ? 32'd2 : 32'd1);
        col_wrap  = 32'(col) == 32'(TI - 1);
        rib_wrap  = rib_sum >= 32'(TH);
        tile_wrap = 32'(tile) == 32'(TW - 1);
        band_wrap = 32'(band) == 32'(NB - 1);
        chan_wrap = 32'(chan) == 32'(C - 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            col        <= '0;
            rib        <= '0;
            tile       <= '0;
            band       <= '0;
            chan       <= '0;
            wr0_en     <= 1'b0;
            wr0_addr   <= '0;
            wr0_data   <= '0;
            wr1_en     <= 1'b0;
            wr1_addr   <= '0;
            wr1_data   <= '0;
            busy       <= 1'b0;
            ch_done    <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            wr0_en     <= 1'b0;
            wr1_en     <= 1'b0;
            ch_done    <= 1'b0;
            frame_done <= 1'b0;
            if (start) begin
                state <= RUN;
                busy  <= 1'b1;
                err   <= 1'b0;
                col   <= '0;
                rib   <= '0;
                tile  <= '0;
                band  <= '0;
                chan  <= '0;
            end else if (state == RUN) begin
                if (p0_v) begin
                    wr0_en   <= 1'b1;
                    wr0_addr <= lin[ADDR_W-1:0];
                    wr0_data <= p0_data;
                    if (dual) begin
                        wr1_en   <= 1'b1;
                        wr1_addr <= lin1[ADDR_W-1:0];
                        wr1_data <= p1_data;
                    end else if (p1_v) begin
                        err <= 1'b1;
                    end
                    if (col_wrap) begin
                        col <= '0;
                        if (rib_wrap) begin
                            rib <= '0;
                            if (tile_wrap) begin
                                tile <= '0;
                                if (band_wrap) begin
                                    band    <= '0;
                                    ch_done <= 1'b1;
                                    if (chan_wrap) begin
                                        chan       <= '0;
                                        frame_done <= 1'b1;
                                        state      <= IDLE;
                                        busy       <= 1'b0;
                                    end else begin
                                        chan <= chan + 1'b1;
                                    end
                                end else begin
                                    band <= band + 1'b1;
                                end
                            end else begin
                                tile <= tile + 1'b1;
                            end
                        end else begin
                            rib <= RW'(rib_sum);
                        end
                    end else begin
                        col <= col + 1'b1;
                    end
                end else if (p1_v) begin
                    err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ofm_tile_collector.sv
// Scoreboard bench: stimulus pushes expected writes, a negedge monitor
// pops and compares them against the write ports.
module tb_ofm_tile_collector;
    localparam int DATA_W = 25;
    localparam int ADDR_W = 16;
    localparam int TI = 16, TW = 4, TH = 5, NB = 13, C = 8;
    localparam int W = TI * TW;
    localparam int H = TH * NB;

    logic              clk = 0;
    logic              rst = 0;
    logic              start = 0;
    logic              p0_v = 0;
    logic [DATA_W-1:0] p0_data = '0;
    logic              p1_v = 0;
    logic [DATA_W-1:0] p1_data = '0;
    logic              wr0_en, wr1_en, busy, ch_done, frame_done, err;
    logic [ADDR_W-1:0] wr0_addr, wr1_addr;
    logic [DATA_W-1:0] wr0_data, wr1_data;

    ofm_tile_collector dut (
        .clk(clk), .rst(rst), .start(start),
        .p0_v(p0_v), .p0_data(p0_data),
        .p1_v(p1_v), .p1_data(p1_data),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .busy(busy), .ch_done(ch_done), .frame_done(frame_done),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int data;
        bit cd;
        bit fd;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int nvec = 0;
    int nerr = 0;

    int m_col = 0, m_rib = 0, m_tile = 0, m_band = 0, m_chan = 0;
    bit m_run = 0;

    function automatic void chk(string name, int act, int req);
        nvec++;
        if (act != req) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endfunction

    // Monitor: every write must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (wr0_en) begin
                if (q0.size() == 0) begin
                    chk("unexpected_wr0", int'(wr0_addr), -1);
                end else begin
                    e = q0.pop_front();
                    chk("wr0_addr", int'(wr0_addr), e.addr);
                    chk("wr0_data", int'(wr0_data), e.data);
                    chk("ch_done", int'(ch_done), int'(e.cd));
                    chk("frame_done", int'(frame_done), int'(e.fd));
                end
            end else if (ch_done || frame_done) begin
                chk("stray_done", int'({ch_done, frame_done}), 0);
            end
            if (wr1_en) begin
                if (q1.size() == 0) begin
                    chk("unexpected_wr1", int'(wr1_addr), -1);
                end else begin
                    e = q1.pop_front();
                    chk("wr1_addr", int'(wr1_addr), e.addr);
                    chk("wr1_data", int'(wr1_data), e.data);
                end
            end
        end
    end

    task automatic model_clear();
        m_col = 0; m_rib = 0; m_tile = 0; m_band = 0; m_chan = 0;
    endtask

    task automatic model_beat(bit d, int a, int b);
        exp_t e, e1;
        bit dl;
        int base;
        base = m_chan * H * W + (m_band * TH + m_rib) * W
             + m_tile * TI + m_col;
        e.addr = base; e.data = a; e.cd = 0; e.fd = 0;
        dl = d && (m_rib != TH - 1);
        if (dl) begin
            e1.addr = base + W; e1.data = b; e1.cd = 0; e1.fd = 0;
            q1.push_back(e1);
        end
        m_col++;
        if (m_col == TI) begin
            m_col = 0;
            m_rib += dl ? 2 : 1;
            if (m_rib >= TH) begin
                m_rib = 0;
                m_tile++;
                if (m_tile == TW) begin
                    m_tile = 0;
                    m_band++;
                    if (m_band == NB) begin
                        m_band = 0;
                        e.cd = 1;
                        m_chan++;
                        if (m_chan == C) begin
                            m_chan = 0;
                            e.fd = 1;
                            m_run = 0;
                        end
                    end
                end
            end
        end
        q0.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the capturing edge
    task automatic beat(bit v0, int d0, bit v1, int d1, bit st);
        p0_v = v0; p0_data = DATA_W'(d0);
        p1_v = v1; p1_data = DATA_W'(d1);
        start = st;
        if (st) begin
            model_clear();
            m_run = 1;
        end else if (m_run && v0) begin
            model_beat(v1, d0, d1);
        end
        @(negedge clk);
        p0_v = 0; p1_v = 0; start = 0;
    endtask

    task automatic do_start();
        beat(0, 0, 0, 0, 1);
    endtask

    task automatic singles(int n, int d0);
        for (int i = 0; i < n; i++) beat(1, d0 + i, 0, 0, 0);
    endtask

    initial begin
        rst = 1;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_wr0_en", int'(wr0_en), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        @(negedge clk);

        // Beats while idle are ignored
        singles(3, 5);
        chk("idle_busy", int'(busy), 0);

        // p1 alone: error, no write; start clears it
        do_start();
        chk("start_busy", int'(busy), 1);
        beat(0, 0, 1, 7, 0);
        chk("p1_alone_err", int'(err), 1);
        chk("p1_alone_wr1", int'(wr1_en), 0);
        do_start();
        chk("start_clr_err", int'(err), 0);

        // Single-beat raster
        singles(16, 1);
        chk("b16_addr", int'(wr0_addr), 15);
        beat(1, 17, 0, 0, 0);
        chk("b17_addr", int'(wr0_addr), 64);
        chk("b17_data", int'(wr0_data), 17);
        singles(63, 18);
        chk("b80_addr", int'(wr0_addr), 4 * 64 + 15);
        beat(1, 81, 0, 0, 0);
        chk("b81_addr", int'(wr0_addr), 16);
        singles(239, 82);
        beat(1, 321, 0, 0, 0);
        chk("b321_addr", int'(wr0_addr), 320);

        // Dual beats
        do_start();
        beat(1, 'hA, 1, 'hB, 0);
        chk("dual_wr0_addr", int'(wr0_addr), 0);
        chk("dual_wr1_addr", int'(wr1_addr), 64);
        chk("dual_wr1_en", int'(wr1_en), 1);
        for (int i = 1; i < 16; i++) beat(1, 100 + i, 1, 200 + i, 0);
        singles(32, 300);
        beat(1, 'h55, 1, 'h66, 0);
        chk("r4_dual_addr", int'(wr0_addr), 256);
        chk("r4_dual_wr1_en", int'(wr1_en), 0);
        chk("r4_dual_err", int'(err), 1);

        // Reset mid-frame discards progress
        do_start();
        singles(100, 1);
        @(negedge clk);
        rst = 1;
        #1;
        chk("mid_rst_addr", int'(wr0_addr), 0);
        chk("mid_rst_data", int'(wr0_data), 0);
        chk("mid_rst_busy", int'(busy), 0);
        m_run = 0;
        model_clear();
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        do_start();
        beat(1, 9, 0, 0, 0);
        chk("post_rst_addr", int'(wr0_addr), 0);

        // Full frame
        do_start();
        singles(4160, 1);
        chk("ch0_done", int'(ch_done), 1);
        chk("ch0_last_addr", int'(wr0_addr), 4159);
        beat(1, 4161, 0, 0, 0);
        chk("ch1_first_addr", int'(wr0_addr), 4160);
        singles(33280 - 4161, 4162);
        chk("frame_done", int'(frame_done), 1);
        chk("frame_last_addr", int'(wr0_addr), 33279);
        @(negedge clk);
        chk("frame_busy", int'(busy), 0);
        beat(1, 1, 0, 0, 0);
        chk("post_frame_wr0", int'(wr0_en), 0);

        // Start collides with the final beat of a frame
        do_start();
        singles(33279, 1);
        beat(1, 7, 0, 0, 1);
        chk("coll_frame_done", int'(frame_done), 0);
        chk("coll_wr0_en", int'(wr0_en), 0);
        chk("coll_busy", int'(busy), 1);
        beat(1, 8, 0, 0, 0);
        chk("coll_next_addr", int'(wr0_addr), 0);

        @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/ofm_tile_collector.md
OFM_TILE_COLLECTOR -- requirements
Module: ofm_tile_collector

Interface
REQ-001 SHALL have parameters: DATA_W=25 (ofm word width); TI=16 (tile width, columns); TW=4 (tiles per band); TH=5 (rows per band); NB=13 (bands per channel); C=8 (output channels); ADDR_W=16, which must satisfy 2^ADDR_W >= C*TH*NB*TI*TW.
REQ-002 SHALL use one clock and an asynchronous, active-high reset.
REQ-003 SHALL have these ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- start  in  1  one-cycle pulse; arms the collector
- p0_v  in  1  port0 beat valid
- p0_data  in  DATA_W  port0 word
- p1_v  in  1  port1 beat valid (dual-row beat)
- p1_data  in  DATA_W  port1 word
- wr0_en  out  1  write strobe, port0 word
- wr0_addr  out  ADDR_W  linear address of port0 word
- wr0_data  out  DATA_W  port0 word, registered
- wr1_en  out  1  write strobe, port1 word
- wr1_addr  out  ADDR_W  linear address of port1 word
- wr1_data  out  DATA_W  port1 word, registered
- busy  out  1  collector armed
- ch_done  out  1  one-cycle pulse, channel complete
- frame_done  out  1  one-cycle pulse, all C channels complete
- err  out  1  sticky protocol error

Function
REQ-004 SHALL define W=TI*TW, H=TH*NB, and linear address = c*H*W + h*W + w.
REQ-005 SHALL keep position counters: col (0..TI-1), row_in_band (0..TH-1), tile (0..TW-1), band (0..NB-1), chan (0..C-1), so that h = band*TH + row_in_band and w = tile*TI + col.
REQ-006 SHALL have two states, IDLE and RUN. start moves the block to RUN with all counters cleared. start while in RUN aborts the current frame and restarts from zero without raising err.
REQ-007 SHALL ignore beats (no writes, no counter change) while in IDLE.
REQ-008 SHALL, in RUN, treat a single beat (p0_v=1, p1_v=0) as: write p0 to (h, w); col+1; at col wrap, row_in_band+1.
REQ-009 SHALL, in RUN, treat a dual beat (p0_v=1, p1_v=1) as: write p0 to (h, w) and p1 to (h+1, w); col+1; at col wrap, row_in_band+2.
REQ-010 SHALL, for a dual beat with row_in_band = TH-1, set err, suppress wr1_en, and process the beat as a single beat.
REQ-011 SHALL, for p1_v=1 with p0_v=0, set err and otherwise ignore the beat.
REQ-012 SHALL treat row_in_band reaching TH as tile complete: row_in_band=0 and tile+1. At tile wrap: tile=0 and band+1. At band wrap: band=0, chan+1, and ch_done pulses.
REQ-013 SHALL, at chan wrap (the last word of channel C-1), pulse ch_done and frame_done together, return to IDLE, and deassert busy on the next cycle.
REQ-014 SHALL register all write outputs: wr*_en/addr/data appear exactly 1 cycle after the accepting beat. ch_done and frame_done align with the wr0_en of the final word.
REQ-015 SHALL accept one beat per cycle with no backpressure. Back-to-back beats SHALL produce back-to-back writes.
REQ-016 SHALL give start priority over a beat in the same cycle: that beat is dropped.
REQ-017 SHALL, when a start pulse and the final beat of a frame occur in the same cycle, leave the block in RUN with counters cleared and no frame_done pulse.
REQ-018 SHALL clear err only on rst or start.

Reset
REQ-019 SHALL, while rst=1, force immediately: state IDLE; all counters 0; wr0_en, wr1_en, busy, ch_done, frame_done, err = 0; wr*_addr and wr*_data = 0.
REQ-020 SHALL, on rst asserted mid-frame, discard all progress. The next start SHALL begin at address 0.

Verification (default parameters: W=64, H=65, 4160 words per channel)
REQ-021 start, then 17 single beats with data 1..17 -> wr0_addr 0..15 carrying data 1..16, then wr0_addr=64 carrying 17, each 1 cycle after its beat.
REQ-022 After 80 single beats (tile 0 complete), beat 81 -> wr0_addr=16. After 320 beats, beat 321 -> wr0_addr=320.
REQ-023 First beat is dual with p0=0xA, p1=0xB -> wr0_addr=0/0xA and wr1_addr=64/0xB in the same cycle. With rows r=4 forced by single beats, a dual beat -> err=1 and wr1_en=0.
REQ-024 4160 single beats -> ch_done on the last write, and the next beat writes address 4160. 33280 beats -> frame_done at address 33279, busy=0, and a further beat produces no write.
REQ-025 rst pulsed after 100 beats -> all outputs 0. Then start plus one beat -> wr0_addr=0.
REQ-026 p1_v alone -> err=1 and no write. A subsequent start -> err=0.
